// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that funnels four byte requesters into one UART transmitter.
// Optional WAIT_DONE watchdog is compiled in when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ack,
    output logic        tx_data_valid,
    output logic [7:0]  tx_parallel_data,
    input  logic        tx_active,
    input  logic        tx_complete,
    output logic [1:0]  grant_id,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  last_grant_reg, last_grant_next;
    logic [1:0]  winner_reg, winner_next;
    logic [7:0]  byte_reg, byte_next;
    logic [3:0]  req_ack_reg, req_ack_next;
    logic        tx_valid_reg, tx_valid_next;
    logic [7:0]  tx_data_reg, tx_data_next;
    logic [1:0]  grant_id_reg, grant_id_next;
    logic        busy_reg;
    logic        timeout_err_reg, timeout_err_next;

    logic [7:0]  req_byte [NUM_REQ];
    logic        sel_found;
    logic [1:0]  sel_idx;
    logic [1:0]  cand;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_byte[gi] = req_data[8*gi +: 8];
    end

    // Walk offsets from farthest to nearest so the requester just after
    // last_grant overwrites everyone else and wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 2'd0;
        cand      = 2'd0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = last_grant_reg + 2'(i);
            if (req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_count_reg;
    logic            wd_hit;
    logic            wd_expired;

    // Pulse is raised as the count reaches the limit; the FSM leaves one cycle later.
    assign wd_hit     = (wd_count_reg == WD_W'(TIMEOUT_CYCLES - 1));
    assign wd_expired = (wd_count_reg == WD_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_count_reg <= '0;
        end else if (state_reg == LAUNCH) begin
            wd_count_reg <= '0;
        end else if (state_reg == WAIT_DONE) begin
            wd_count_reg <= wd_count_reg + WD_W'(1);
        end
    end
`else
    logic wd_hit;
    logic wd_expired;

    assign wd_hit     = 1'b0;
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_next       = state_reg;
        last_grant_next  = last_grant_reg;
        winner_next      = winner_reg;
        byte_next        = byte_reg;
        req_ack_next     = 4'b0000;
        tx_valid_next    = 1'b0;
        tx_data_next     = tx_data_reg;
        grant_id_next    = grant_id_reg;
        timeout_err_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (sel_found && !tx_active) begin
                    winner_next   = sel_idx;
                    byte_next     = req_byte[sel_idx];
                    grant_id_next = sel_idx;
                    state_next    = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_valid_next   = 1'b1;
                tx_data_next    = byte_reg;
                req_ack_next    = 4'b0001 << winner_reg;
                last_grant_next = winner_reg;
                state_next      = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_complete) begin
                    state_next = IDLE;
                end else if (wd_expired) begin
                    state_next = IDLE;
                end else if (wd_hit) begin
                    timeout_err_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            last_grant_reg  <= 2'd3;
            winner_reg      <= 2'd0;
            byte_reg        <= 8'h00;
            req_ack_reg     <= 4'b0000;
            tx_valid_reg    <= 1'b0;
            tx_data_reg     <= 8'h00;
            grant_id_reg    <= 2'd0;
            busy_reg        <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            last_grant_reg  <= last_grant_next;
            winner_reg      <= winner_next;
            byte_reg        <= byte_next;
            req_ack_reg     <= req_ack_next;
            tx_valid_reg    <= tx_valid_next;
            tx_data_reg     <= tx_data_next;
            grant_id_reg    <= grant_id_next;
            busy_reg        <= (state_next != IDLE);
            timeout_err_reg <= timeout_err_next;
        end
    end

    assign req_ack          = req_ack_reg;
    assign tx_data_valid    = tx_valid_reg;
    assign tx_parallel_data = tx_data_reg;
    assign grant_id         = grant_id_reg;
    assign busy             = busy_reg;
    assign timeout_err      = timeout_err_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table for rotation plus hand sequences
// for busy line, mid-frame reset and the optional watchdog (UART_ARB_TIMEOUT_EN).
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req_valid = 4'b0000;
    logic [31:0] req_data = 32'h0;
    logic        tx_active = 1'b0;
    logic        tx_complete = 1'b0;
    logic [3:0]  req_ack;
    logic        tx_data_valid;
    logic [7:0]  tx_parallel_data;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ack(req_ack), .tx_data_valid(tx_data_valid),
        .tx_parallel_data(tx_parallel_data), .tx_active(tx_active),
        .tx_complete(tx_complete), .grant_id(grant_id), .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] valid;
        logic [7:0] exp_byte;
        logic [3:0] exp_ack;
        logic [1:0] exp_gid;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tx_active = 1'b0;
        tx_complete = 1'b0;
        #1;
        check("rst_outputs", {19'h0, tx_data_valid, tx_parallel_data, req_ack},
              32'h0);
        check("rst_status", {29'h0, grant_id, busy}, 32'h0);
        check("rst_timeout_err", {31'h0, timeout_err}, 32'h0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_launch(output logic [7:0] b, output logic [3:0] a,
                               output logic [1:0] g, output int lat);
        b = 8'h00;
        a = 4'h0;
        g = 2'd0;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (tx_data_valid) begin
                b = tx_parallel_data;
                a = req_ack;
                g = grant_id;
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL launch_wait: got no tx_data_valid within 100 cycles");
        end
    endtask

    // Transmitter stand-in: busy for n cycles, then a one-cycle tx_complete.
    task automatic frame_done(input int n);
        tx_active = 1'b1;
        step();
        check("tv_one_cycle", {27'h0, tx_data_valid, req_ack}, 32'h0);
        repeat (n - 1) step();
        tx_active = 1'b0;
        tx_complete = 1'b1;
        step();
        tx_complete = 1'b0;
        check("busy_after_complete", {31'h0, busy}, 32'h0);
    endtask

    logic [7:0] got_b;
    logic [3:0] got_a;
    logic [1:0] got_g;
    int         lat;
    int         cnt;

    initial begin
        vecs[0]  = '{4'b1111, 8'hA0, 4'b0001, 2'd0};
        vecs[1]  = '{4'b1111, 8'hA1, 4'b0010, 2'd1};
        vecs[2]  = '{4'b1111, 8'hA2, 4'b0100, 2'd2};
        vecs[3]  = '{4'b1111, 8'hA3, 4'b1000, 2'd3};
        vecs[4]  = '{4'b1111, 8'hA0, 4'b0001, 2'd0};
        vecs[5]  = '{4'b1001, 8'hA3, 4'b1000, 2'd3};
        vecs[6]  = '{4'b1001, 8'hA0, 4'b0001, 2'd0};
        vecs[7]  = '{4'b0110, 8'hA1, 4'b0010, 2'd1};
        vecs[8]  = '{4'b0100, 8'hA2, 4'b0100, 2'd2};
        vecs[9]  = '{4'b0011, 8'hA0, 4'b0001, 2'd0};
        vecs[10] = '{4'b0010, 8'hA1, 4'b0010, 2'd1};

        #2;
        do_reset();

        // Single request; tx_complete held during IDLE/LAUNCH must be ignored.
        req_data = 32'h0025_0000;
        req_valid = 4'b0100;
        tx_complete = 1'b1;
        wait_launch(got_b, got_a, got_g, lat);
        tx_complete = 1'b0;
        req_valid = 4'b0000;
        check("single_latency", lat, 2);
        check("single_loopback", {24'h0, got_b}, 32'h25);
        check("single_ack", {28'h0, got_a}, 32'h4);
        check("single_gid", {30'h0, got_g}, 32'h2);
        tx_active = 1'b1;
        repeat (3) step();
        check("early_complete_ignored", {31'h0, busy}, 32'h1);
        frame_done(3);
        repeat (3) step();
        check("data_hold", {22'h0, grant_id, tx_parallel_data}, {22'h0, 2'd2, 8'h25});

        // Rotation and masked-requester table.
        do_reset();
        req_data = 32'hA3A2_A1A0;
        for (int v = 0; v < 11; v++) begin
            req_valid = vecs[v].valid;
            wait_launch(got_b, got_a, got_g, lat);
            $display("vec %0d valid=%b byte=%h ack=%b gid=%0d lat=%0d",
                     v, vecs[v].valid, got_b, got_a, got_g, lat);
            check("vec_latency", lat, 2);
            check("vec_byte", {24'h0, got_b}, {24'h0, vecs[v].exp_byte});
            check("vec_ack", {28'h0, got_a}, {28'h0, vecs[v].exp_ack});
            check("vec_gid", {30'h0, got_g}, {30'h0, vecs[v].exp_gid});
            frame_done(3);
        end
        req_valid = 4'b0000;

        // Busy line blocks grants until tx_active drops.
        do_reset();
        req_data = 32'h0000_0011;
        tx_active = 1'b1;
        req_valid = 4'b0001;
        cnt = 0;
        repeat (10) begin
            step();
            if (tx_data_valid || busy) cnt++;
        end
        check("busy_line_no_grant", cnt, 0);
        tx_active = 1'b0;
        wait_launch(got_b, got_a, got_g, lat);
        check("busy_line_latency", lat, 2);
        check("busy_line_byte", {24'h0, got_b}, 32'h11);

        // Reset five cycles into WAIT_DONE; requester 0 stays valid.
        tx_active = 1'b1;
        repeat (5) step();
        check("midframe_busy", {31'h0, busy}, 32'h1);
        do_reset();
        wait_launch(got_b, got_a, got_g, lat);
        req_valid = 4'b0000;
        check("post_reset_latency", lat, 2);
        check("post_reset_byte", {24'h0, got_b}, 32'h11);
        check("post_reset_ack", {28'h0, got_a}, 32'h1);
        frame_done(3);
        cnt = 0;
        repeat (5) begin
            step();
            if (req_ack != 4'b0000) cnt++;
        end
        check("no_extra_ack", cnt, 0);

        // Watchdog behaviour.
        do_reset();
        req_valid = 4'b0001;
        wait_launch(got_b, got_a, got_g, lat);
        req_valid = 4'b0000;
        tx_active = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
        cnt = -1;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (timeout_err) begin
                cnt = i;
                break;
            end
        end
        check("wd_pulse_cycle", cnt, 50);
        check("wd_busy_at_pulse", {31'h0, busy}, 32'h1);
        step();
        check("wd_busy_falls", {30'h0, busy, timeout_err}, 32'h0);

        do_reset();
        req_valid = 4'b0001;
        wait_launch(got_b, got_a, got_g, lat);
        req_valid = 4'b0000;
        tx_active = 1'b1;
        repeat (49) step();
        tx_active = 1'b0;
        tx_complete = 1'b1;
        cnt = 0;
        step();
        if (timeout_err) cnt++;
        tx_complete = 1'b0;
        repeat (3) begin
            step();
            if (timeout_err) cnt++;
        end
        check("wd_boundary_no_err", cnt, 0);
        check("wd_boundary_idle", {31'h0, busy}, 32'h0);
`else
        cnt = 0;
        repeat (200) begin
            step();
            if (timeout_err) cnt++;
        end
        check("no_wd_err", cnt, 0);
        check("no_wd_still_busy", {31'h0, busy}, 32'h1);
        frame_done(2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requester ports (fixed at 4; other values unsupported).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 2000, meaning the WAIT_DONE watchdog limit in clk cycles (must be ≥ 10*clocks_per_bit of the transmitter).
REQ-003 The block SHALL have port clk, input, 1, the single system clock (all logic posedge).
REQ-004 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid, input, 4, per-requester byte-pending flags, level, held until acked.
REQ-006 The block SHALL have port req_data, input, 32, the flattened request bytes, requester i at bits [8i+7:8i].
REQ-007 The block SHALL have port req_ack, output, 4, a one-hot one-cycle pulse marking the byte accepted.
REQ-008 The block SHALL have port tx_data_valid, output, 1, the transmitter start strobe.
REQ-009 The block SHALL have port tx_parallel_data, output, 8, the byte to the transmitter.
REQ-010 The block SHALL have port tx_active, input, 1, the transmitter busy flag.
REQ-011 The block SHALL have port tx_complete, input, 1, the transmitter end-of-frame pulse.
REQ-012 The block SHALL have port grant_id, output, 2, the index of the current or last granted requester.
REQ-013 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 The block SHALL have port timeout_err, output, 1, a one-cycle watchdog-expiry pulse.

Function
REQ-015 The FSM SHALL have states IDLE, LAUNCH and WAIT_DONE, with all outputs registered.
REQ-016 In IDLE, with any req_valid bit high and tx_active low, the FSM SHALL select a winner round-robin starting at (last_grant+1) mod 4, store its byte and index, and move to LAUNCH.
REQ-017 In IDLE, while tx_active is high, the FSM SHALL stay in IDLE and make no grant.
REQ-018 In LAUNCH, tx_data_valid SHALL be high for exactly one cycle with tx_parallel_data equal to the stored byte, req_ack[winner] SHALL pulse in that same cycle, last_grant SHALL update to the winner, and the FSM SHALL move to WAIT_DONE.
REQ-019 In WAIT_DONE, tx_complete high SHALL return the FSM to IDLE on the next edge, with no grant evaluated in that cycle.
REQ-020 The earliest next tx_data_valid after tx_complete SHALL be 2 cycles after the tx_complete cycle.
REQ-021 Latency SHALL be exactly 2 cycles from req_valid sampled high in IDLE to tx_data_valid.
REQ-022 tx_complete outside WAIT_DONE SHALL be ignored.
REQ-023 tx_parallel_data SHALL hold its value between launches.
REQ-024 A req_valid bit deasserted before its ack SHALL NOT be granted.
REQ-025 A req_valid bit deasserted after selection SHALL NOT cancel the launch.
REQ-026 With all four requesters continuously valid, grants SHALL rotate 0,1,2,3,0, and no requester SHALL wait more than 3 frames.
REQ-027 Reset-out last_grant SHALL be 3, so that requester 0 wins first.

Reset
REQ-028 On rst_n low, asynchronously, the block SHALL force state IDLE, tx_data_valid=0, tx_parallel_data=8'h00, req_ack=0, grant_id=0, busy=0, timeout_err=0, last_grant=3 and the watchdog count to 0.
REQ-029 A reset asserted mid-frame SHALL abandon the frame, and the requester SHALL NOT receive a second ack for it.
REQ-030 Reset deassertion SHALL be synchronous by design, with the first grant possible on the first edge after release.

Configuration
REQ-031 Macro UART_ARB_TIMEOUT_EN defined SHALL enable the watchdog, clearing the count on WAIT_DONE entry and incrementing it each WAIT_DONE cycle.
REQ-032 When the watchdog count reaches TIMEOUT_CYCLES without tx_complete, timeout_err SHALL pulse for 1 cycle and the FSM SHALL return to IDLE.
REQ-033 A tx_complete arriving in the same cycle the watchdog limit is reached SHALL take priority, with no timeout_err.
REQ-034 With UART_ARB_TIMEOUT_EN undefined, the block SHALL contain no counter, timeout_err SHALL be constant 0, and WAIT_DONE SHALL wait indefinitely.

Verification
REQ-035 Single request: req_valid=4'b0100, byte 8'h25 -> tx_data_valid pulses 2 cycles later with data 8'h25, req_ack=4'b0100 in the same cycle, and the receiver loopback outputs 8'h25.
REQ-036 All valid: bytes 0xA0–0xA3 held continuously -> transmitted order A0,A1,A2,A3,A0, one launch per tx_complete.
REQ-037 Busy line: tx_active forced high with req_valid=4'b0001 -> no tx_data_valid until tx_active drops, then launch 2 cycles later.
REQ-038 Mid-frame reset: rst_n low 5 cycles into WAIT_DONE -> all outputs reach reset values immediately, and after release requester 0 (byte 8'h11, still valid) is granted first.
REQ-039 Watchdog (macro defined, TIMEOUT_CYCLES=50): tx_complete held 0 -> timeout_err pulses 50 cycles after WAIT_DONE entry, and busy falls the next cycle.
REQ-040 Watchdog boundary (macro defined): tx_complete pulsed on cycle 50 -> timeout_err stays 0.
